// File: rtl/gpr_file_sb.sv
// General-purpose register file: two combinational bypassed read ports, ALU and
// load write-back ports, and a per-register busy scoreboard for decode hazard stalls.
module gpr_file_sb #(
    parameter int WordSize = 32,
    parameter int AddrBits = 5,
    parameter bit ZeroReg  = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [AddrBits-1:0] rs1n,
    input  logic [AddrBits-1:0] rs2n,
    output logic [WordSize-1:0] rs1d,
    output logic [WordSize-1:0] rs2d,
    output logic                rs1_busy,
    output logic                rs2_busy,
    input  logic                wbe0,
    input  logic [AddrBits-1:0] rd0n,
    input  logic [WordSize-1:0] rd0d,
    input  logic                wbe1,
    input  logic [AddrBits-1:0] rd1n,
    input  logic [WordSize-1:0] rd1d,
    input  logic                iss_en,
    input  logic [AddrBits-1:0] iss_rdn,
    input  logic                flush
);

    localparam int NumRegs = 2 ** AddrBits;

    logic [WordSize-1:0] regs_q [NumRegs];
    logic [NumRegs-1:0]  busy_q;
    logic [NumRegs-1:0]  busy_d;
    logic [NumRegs-1:0]  wb_hit;
    logic                wr0;
    logic                wr1;

    // Port 0 is dropped when the load port targets the same register.
    always_comb begin
        wr1 = wbe1 && !(ZeroReg && (rd1n == '0));
        wr0 = wbe0 && !(ZeroReg && (rd0n == '0)) && !(wbe1 && (rd1n == rd0n));
    end

    // Per-bit priority: flush, then issue (set), then write-back (clear).
    always_comb begin
        wb_hit = '0;
        busy_d = busy_q;
        for (int i = 0; i < NumRegs; i++) begin
            wb_hit[i] = (wbe0 && (rd0n == AddrBits'(i))) || (wbe1 && (rd1n == AddrBits'(i)));
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (iss_en && (iss_rdn == AddrBits'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wb_hit[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZeroReg) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NumRegs; i++) begin
                if (wr1 && (rd1n == AddrBits'(i))) begin
                    regs_q[i] <= rd1d;
                end else if (wr0 && (rd0n == AddrBits'(i))) begin
                    regs_q[i] <= rd0d;
                end
            end
        end
    end

    // While reset is held the bypass paths are masked so the outputs read zero.
    function automatic logic [WordSize-1:0] read_data(input logic [AddrBits-1:0] idx);
        logic [WordSize-1:0] d;
        if (!rstn || (ZeroReg && (idx == '0))) begin
            d = '0;
        end else if (wbe1 && (rd1n == idx)) begin
            d = rd1d;
        end else if (wbe0 && (rd0n == idx)) begin
            d = rd0d;
        end else begin
            d = regs_q[idx];
        end
        return d;
    endfunction

    function automatic logic read_busy(input logic [AddrBits-1:0] idx);
        return rstn && !(ZeroReg && (idx == '0)) && busy_q[idx] && !wb_hit[idx] && !flush;
    endfunction

    always_comb begin
        rs1d     = read_data(rs1n);
        rs2d     = read_data(rs2n);
        rs1_busy = read_busy(rs1n);
        rs2_busy = read_busy(rs2n);
    end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
- Parametrised next-generation general-purpose register file for the core.
- Two read ports and two write-back ports: port 0 for ALU results, port 1 for load results.
- Reads are write-through bypassed, so a register being written in the current cycle reads back the new value.
- An integrated scoreboard keeps one busy bit per register. Issue marks the destination busy, write-back clears it, and flush clears every busy bit. Decode uses the busy bits for hazard stalls.

Parameters:
- WordSize, 32, data width of each register.
- AddrBits, 5, register index width; NumRegs = 2**AddrBits.
- ZeroReg, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- rs1n  input  AddrBits  read port 1 index.
- rs2n  input  AddrBits  read port 2 index.
- rs1d  output  WordSize  read port 1 data.
- rs2d  output  WordSize  read port 2 data.
- rs1_busy  output  1  scoreboard bit for rs1n.
- rs2_busy  output  1  scoreboard bit for rs2n.
- wbe0  input  1  write-back enable, port 0 (ALU).
- rd0n  input  AddrBits  write-back index, port 0.
- rd0d  input  WordSize  write-back data, port 0.
- wbe1  input  1  write-back enable, port 1 (load).
- rd1n  input  AddrBits  write-back index, port 1.
- rd1d  input  WordSize  write-back data, port 1.
- iss_en  input  1  issue strobe; mark iss_rdn busy.
- iss_rdn  input  AddrBits  destination index of the issuing instruction.
- flush  input  1  clear all busy bits (pipeline flush).

Behaviour:
- Reset (rstn low, asynchronous): all registers = 0 and all busy bits = 0. Outputs immediately follow, so rsXd = 0 and rsX_busy = 0. Inputs are ignored while reset is held.
- Write, at posedge clk:
  - If wbeK and the target is not the zero register, register[rdKn] <= rdKd.
  - Same index on both ports: port 1 (load) wins; port 0 is dropped.
- Read is combinational, zero latency:
  - Zero register (ZeroReg=1, index 0): data 0.
  - Else if wbe1 && rd1n==rsXn: rd1d.
  - Else if wbe0 && rd0n==rsXn: rd0d.
  - Else: stored register.
- Scoreboard, at posedge clk, in priority order per bit:
  - flush: all bits cleared. A same-cycle iss_en is ignored.
  - Else set if iss_en && iss_rdn==i.
  - Else clear if (wbe0 && rd0n==i) || (wbe1 && rd1n==i).
  - Else hold.
  - Set-over-clear on the same index: the new in-flight writer owns the register.
  - Issue to the zero register (ZeroReg=1) is ignored.
- Busy read is combinational:
  - rsX_busy = busy[rsXn] && !(same-cycle write-back clear of rsXn) && !flush.
  - This bypass lets the consumer proceed in the write-back cycle.
  - The zero register always reads not-busy.
  - An issue in the current cycle is NOT visible until the next cycle.
- Write-back to a non-busy register is legal: data is written and the busy bit stays 0.
- Reset mid-operation: state clears asynchronously and in-flight writes are lost. The first write is accepted on the first rising edge after rstn deasserts.
- Writes, issues and flushes to any index wrap within NumRegs; no out-of-range case exists.

Test Plan:
- Reset: write 0xDEADBEEF to r5, issue r7, then pulse rstn low mid-cycle -> rs1n=5 gives rs1d=0 and rs1_busy(rs1n=7)=0 immediately, before the next edge.
- Zero register: wbe0=1, rd0n=0, rd0d=0xFFFFFFFF; iss_en with iss_rdn=0 -> rs1d(0)=0, rs1_busy=0 on all following cycles.
- Dual-write collision: wbe0 with r3=0x11111111 and wbe1 with r3=0x22222222 in the same cycle -> same-cycle bypass reads 0x22222222, and after the edge r3=0x22222222.
- Bypass: r9 holds 0xA5A5A5A5; drive wbe0 with r9=0x12345678 and rs2n=9 -> rs2d=0x12345678 in that cycle, before the edge.
- Scoreboard life cycle, on r4:
  - iss_en r4 at cycle N -> rs1_busy=0 at N, 1 at N+1.
  - Load write-back at N+3 -> rs1_busy=0 combinationally at N+3, 0 at N+4.
  - iss_en r4 together with wbe0 r4 -> r4 stays busy.
- Flush: issue r1, r2, r31 over three cycles, then assert flush together with iss_en r6 -> all busy bits = 0 the next cycle, including r6; register data unchanged.
